alu_op_sequencer: RTL and testbench

//  Control-step sequencer driving the Phase 1 ALU and datapath strobes. Runs fetch (T0-T2) then execute (T3-T6).

---
 rtl/alu_seq_pkg.sv | 55 +++++
 rtl/alu_op_decode.sv | 34 +++
 rtl/alu_op_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU control-step sequencer: opcodes, alu_sel bit indices,
// state encoding and opcode classes. MUL/DIV support is gated by ALU_SEQ_MULDIV_EN.
package alu_seq_pkg;

    localparam int OPW  = 5;
    localparam int NSEL = 14;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_SHR  = 5'b00101;
    localparam logic [OPW-1:0] OP_SHRA = 5'b00110;
    localparam logic [OPW-1:0] OP_SHL  = 5'b00111;
    localparam logic [OPW-1:0] OP_ROR  = 5'b01000;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01001;
    localparam logic [OPW-1:0] OP_AND  = 5'b01010;
    localparam logic [OPW-1:0] OP_OR   = 5'b01011;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10010;

    localparam int SEL_ADD   = 0;
    localparam int SEL_SUB   = 1;
    localparam int SEL_MUL   = 2;
    localparam int SEL_DIV   = 3;
    localparam int SEL_AND   = 4;
    localparam int SEL_OR    = 5;
    localparam int SEL_SHR   = 6;
    localparam int SEL_SHRA  = 7;
    localparam int SEL_SHL   = 8;
    localparam int SEL_ROR   = 9;
    localparam int SEL_ROL   = 10;
    localparam int SEL_NEG   = 11;
    localparam int SEL_NOT   = 12;
    localparam int SEL_INCPC = 13;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_T0   = 3'd1;
    localparam logic [2:0] ST_T1   = 3'd2;
    localparam logic [2:0] ST_T2   = 3'd3;
    localparam logic [2:0] ST_T3   = 3'd4;
    localparam logic [2:0] ST_T4   = 3'd5;
    localparam logic [2:0] ST_T5   = 3'd6;
    localparam logic [2:0] ST_T6   = 3'd7;

    localparam logic [1:0] CLS_TWO_OP  = 2'd0;
    localparam logic [1:0] CLS_UNARY   = 2'd1;
    localparam logic [1:0] CLS_MULDIV  = 2'd2;
    localparam logic [1:0] CLS_ILLEGAL = 2'd3;

    function automatic logic [NSEL-1:0] sel_bit(input int unsigned idx);
        sel_bit = {{(NSEL-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: 5-bit opcode -> one-hot ALU select and operation class.
// MUL/DIV decode only when ALU_SEQ_MULDIV_EN is defined; otherwise they classify as illegal.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [OPW-1:0]  op,
    output logic [NSEL-1:0] sel,
    output logic [1:0]      cls
);

    always_comb begin
        sel = '0;
        cls = CLS_ILLEGAL;
        case (op)
            OP_ADD:  begin sel = sel_bit(SEL_ADD);  cls = CLS_TWO_OP; end
            OP_SUB:  begin sel = sel_bit(SEL_SUB);  cls = CLS_TWO_OP; end
            OP_SHR:  begin sel = sel_bit(SEL_SHR);  cls = CLS_TWO_OP; end
            OP_SHRA: begin sel = sel_bit(SEL_SHRA); cls = CLS_TWO_OP; end
            OP_SHL:  begin sel = sel_bit(SEL_SHL);  cls = CLS_TWO_OP; end
            OP_ROR:  begin sel = sel_bit(SEL_ROR);  cls = CLS_TWO_OP; end
            OP_ROL:  begin sel = sel_bit(SEL_ROL);  cls = CLS_TWO_OP; end
            OP_AND:  begin sel = sel_bit(SEL_AND);  cls = CLS_TWO_OP; end
            OP_OR:   begin sel = sel_bit(SEL_OR);   cls = CLS_TWO_OP; end
`ifdef ALU_SEQ_MULDIV_EN
            OP_MUL:  begin sel = sel_bit(SEL_MUL);  cls = CLS_MULDIV; end
            OP_DIV:  begin sel = sel_bit(SEL_DIV);  cls = CLS_MULDIV; end
`endif
            OP_NEG:  begin sel = sel_bit(SEL_NEG);  cls = CLS_UNARY;  end
            OP_NOT:  begin sel = sel_bit(SEL_NOT);  cls = CLS_UNARY;  end
            default: begin sel = '0;                cls = CLS_ILLEGAL; end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Fetch/execute control-step sequencer for the Phase 1 ALU datapath (Moore strobes).
// Define ALU_SEQ_MULDIV_EN to enable MUL/DIV and the T6 HI-write step.
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic            clock,
    input  logic            clear,
    input  logic            run,
    input  logic [31:0]     ir,
    input  logic            mem_rdy,
    output logic [NSEL-1:0] alu_sel,
    output logic            pc_out,
    output logic            pc_in,
    output logic            mar_in,
    output logic            mdr_in,
    output logic            mdr_out,
    output logic            rd,
    output logic            ir_in,
    output logic            gra,
    output logic            grb,
    output logic            grc,
    output logic            r_out,
    output logic            r_in,
    output logic            y_in,
    output logic            z_in,
    output logic            zlo_out,
    output logic            zhi_out,
    output logic            lo_in,
    output logic            hi_in,
    output logic            busy,
    output logic            illegal
);

    logic [2:0]      state_q, state_d;
    logic [OPW-1:0]  op_q, op_d;
    logic            pc_done_q, pc_done_d;
    logic            illegal_q, illegal_d;
    logic [NSEL-1:0] ir_sel, op_sel;
    logic [1:0]      ir_cls, op_cls;
    logic            unused_bits;

    // The IR-side decoder only decides legality at the T2->T3 edge; its select is not needed.
    alu_op_decode u_dec_ir (.op(ir[31:27]), .sel(ir_sel), .cls(ir_cls));
    alu_op_decode u_dec_op (.op(op_q),      .sel(op_sel), .cls(op_cls));

    assign unused_bits = ^{ir[26:0], ir_sel};

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        pc_done_d = 1'b0;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1: begin
                pc_done_d = 1'b1;
                if (mem_rdy) state_d = ST_T2;
            end
            ST_T2: begin
                op_d = ir[31:27];
                if (ir_cls == CLS_ILLEGAL) begin
                    illegal_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_T3;
                end
            end
            ST_T3: state_d = ST_T4;
            ST_T4: state_d = ST_T5;
            ST_T5: begin
`ifdef ALU_SEQ_MULDIV_EN
                if (op_cls == CLS_MULDIV) state_d = ST_T6;
                else
`endif
                state_d = run ? ST_T0 : ST_IDLE;
            end
`ifdef ALU_SEQ_MULDIV_EN
            ST_T6: state_d = run ? ST_T0 : ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            pc_done_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            pc_done_q <= pc_done_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes depend only on state, op_q and pc_done_q so they stay glitch-free Moore outputs.
    always_comb begin
        alu_sel = '0;
        pc_out  = 1'b0;
        pc_in   = 1'b0;
        mar_in  = 1'b0;
        mdr_in  = 1'b0;
        mdr_out = 1'b0;
        rd      = 1'b0;
        ir_in   = 1'b0;
        gra     = 1'b0;
        grb     = 1'b0;
        grc     = 1'b0;
        r_out   = 1'b0;
        r_in    = 1'b0;
        y_in    = 1'b0;
        z_in    = 1'b0;
        zlo_out = 1'b0;
        zhi_out = 1'b0;
        lo_in   = 1'b0;
        hi_in   = 1'b0;
        case (state_q)
            ST_T0: begin
                pc_out  = 1'b1;
                mar_in  = 1'b1;
                z_in    = 1'b1;
                alu_sel = sel_bit(SEL_INCPC);
            end
            ST_T1: begin
                mdr_in = 1'b1;
                if (!pc_done_q) begin
                    zlo_out = 1'b1;
                    pc_in   = 1'b1;
                    rd      = 1'b1;
                end
            end
            ST_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            ST_T3: begin
                if (op_cls == CLS_TWO_OP) begin
                    grb   = 1'b1;
                    r_out = 1'b1;
                    y_in  = 1'b1;
                end
`ifdef ALU_SEQ_MULDIV_EN
                if (op_cls == CLS_MULDIV) begin
                    gra   = 1'b1;
                    r_out = 1'b1;
                    y_in  = 1'b1;
                end
`endif
            end
            ST_T4: begin
                grc     = (op_cls == CLS_TWO_OP);
                grb     = (op_cls != CLS_TWO_OP);
                r_out   = 1'b1;
                z_in    = 1'b1;
                alu_sel = op_sel;
            end
            ST_T5: begin
                zlo_out = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
                if (op_cls == CLS_MULDIV) begin
                    lo_in = 1'b1;
                end else begin
                    gra  = 1'b1;
                    r_in = 1'b1;
                end
`else
                gra  = 1'b1;
                r_in = 1'b1;
`endif
            end
`ifdef ALU_SEQ_MULDIV_EN
            ST_T6: begin
                zhi_out = 1'b1;
                hi_in   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer; MUL expectations follow ALU_SEQ_MULDIV_EN.
module tb_alu_op_sequencer;

    logic        clock;
    logic        clear;
    logic        run;
    logic [31:0] ir;
    logic        mem_rdy;
    logic [13:0] alu_sel;
    logic pc_out, pc_in, mar_in, mdr_in, mdr_out, rd, ir_in;
    logic gra, grb, grc, r_out, r_in, y_in, z_in;
    logic zlo_out, zhi_out, lo_in, hi_in, busy, illegal;

    int total_checks = 0;
    int bad_checks   = 0;

    localparam logic [19:0] B_PC_OUT  = 20'h80000;
    localparam logic [19:0] B_PC_IN   = 20'h40000;
    localparam logic [19:0] B_MAR_IN  = 20'h20000;
    localparam logic [19:0] B_MDR_IN  = 20'h10000;
    localparam logic [19:0] B_MDR_OUT = 20'h08000;
    localparam logic [19:0] B_RD      = 20'h04000;
    localparam logic [19:0] B_IR_IN   = 20'h02000;
    localparam logic [19:0] B_GRA     = 20'h01000;
    localparam logic [19:0] B_GRB     = 20'h00800;
    localparam logic [19:0] B_GRC     = 20'h00400;
    localparam logic [19:0] B_R_OUT   = 20'h00200;
    localparam logic [19:0] B_R_IN    = 20'h00100;
    localparam logic [19:0] B_Y_IN    = 20'h00080;
    localparam logic [19:0] B_Z_IN    = 20'h00040;
    localparam logic [19:0] B_ZLO     = 20'h00020;
    localparam logic [19:0] B_ZHI     = 20'h00010;
    localparam logic [19:0] B_LO_IN   = 20'h00008;
    localparam logic [19:0] B_HI_IN   = 20'h00004;
    localparam logic [19:0] B_BUSY    = 20'h00002;
    localparam logic [19:0] B_ILL     = 20'h00001;

    localparam logic [19:0] E_T0 = B_PC_OUT | B_MAR_IN | B_Z_IN | B_BUSY;
    localparam logic [19:0] E_T1 = B_ZLO | B_PC_IN | B_RD | B_MDR_IN | B_BUSY;
    localparam logic [19:0] E_T2 = B_MDR_OUT | B_IR_IN | B_BUSY;
    localparam logic [19:0] E_T3_TWO = B_GRB | B_R_OUT | B_Y_IN | B_BUSY;
    localparam logic [19:0] E_T4_TWO = B_GRC | B_R_OUT | B_Z_IN | B_BUSY;
    localparam logic [19:0] E_T4_UN  = B_GRB | B_R_OUT | B_Z_IN | B_BUSY;
    localparam logic [19:0] E_T5     = B_ZLO | B_GRA | B_R_IN | B_BUSY;
    localparam logic [13:0] SEL_INC  = 14'h2000;

    alu_op_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_rdy(mem_rdy),
        .alu_sel(alu_sel),
        .pc_out(pc_out), .pc_in(pc_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .mdr_out(mdr_out), .rd(rd), .ir_in(ir_in),
        .gra(gra), .grb(grb), .grc(grc), .r_out(r_out), .r_in(r_in),
        .y_in(y_in), .z_in(z_in),
        .zlo_out(zlo_out), .zhi_out(zhi_out), .lo_in(lo_in), .hi_in(hi_in),
        .busy(busy), .illegal(illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [19:0] strobes();
        strobes = {pc_out, pc_in, mar_in, mdr_in, mdr_out, rd, ir_in,
                   gra, grb, grc, r_out, r_in, y_in, z_in,
                   zlo_out, zhi_out, lo_in, hi_in, busy, illegal};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic checkStep(input string tag, input logic [19:0] exp_strb, input logic [13:0] exp_sel);
        checkOutput({tag, "/strb"}, {12'h0, strobes()}, {12'h0, exp_strb});
        checkOutput({tag, "/sel"}, {18'h0, alu_sel}, {18'h0, exp_sel});
    endtask

    // Starts an instruction from IDLE and walks the fetch steps T0..T2 with memory ready.
    task automatic applyStimulus(input string tag, input logic [4:0] op, input logic keep_run);
        ir      = {op, 27'h0};
        run     = 1'b1;
        mem_rdy = 1'b1;
        tick();
        checkStep({tag, "_t0"}, E_T0, SEL_INC);
        run = keep_run;
        tick();
        checkStep({tag, "_t1"}, E_T1, 14'h0);
        tick();
        checkStep({tag, "_t2"}, E_T2, 14'h0);
    endtask

    logic [4:0]  tbl_op  [4];
    logic [13:0] tbl_sel [4];
    logic        tbl_un  [4];

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clear   = 1'b1;
        run     = 1'b0;
        ir      = '0;
        mem_rdy = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        tick();
        checkStep("reset", 20'h0, 14'h0);

        applyStimulus("add", 5'b00011, 1'b0);
        tick(); checkStep("add_t3", E_T3_TWO, 14'h0);
        tick(); checkStep("add_t4", E_T4_TWO, 14'h0001);
        tick(); checkStep("add_t5", E_T5, 14'h0);
        tick(); checkStep("add_idle", 20'h0, 14'h0);

        applyStimulus("abort", 5'b00011, 1'b0);
        tick();
        tick(); checkStep("abort_t4", E_T4_TWO, 14'h0001);
        clear = 1'b1;
        tick(); checkStep("abort_idle", 20'h0, 14'h0);
        clear = 1'b0;
        tick(); checkStep("abort_stay", 20'h0, 14'h0);

        ir      = {5'b00100, 27'h0};
        run     = 1'b1;
        mem_rdy = 1'b0;
        tick(); checkStep("wait_t0", E_T0, SEL_INC);
        run = 1'b0;
        tick(); checkStep("wait_t1a", E_T1, 14'h0);
        tick(); checkStep("wait_t1b", B_MDR_IN | B_BUSY, 14'h0);
        tick(); checkStep("wait_t1c", B_MDR_IN | B_BUSY, 14'h0);
        tick(); checkStep("wait_t1d", B_MDR_IN | B_BUSY, 14'h0);
        mem_rdy = 1'b1;
        tick(); checkStep("wait_t2", E_T2, 14'h0);
        tick(); checkStep("sub_t3", E_T3_TWO, 14'h0);
        tick(); checkStep("sub_t4", E_T4_TWO, 14'h0002);
        tick(); checkStep("sub_t5", E_T5, 14'h0);
        tick(); checkStep("sub_idle", 20'h0, 14'h0);

        applyStimulus("not", 5'b10010, 1'b1);
        tick(); checkStep("not_t3", B_BUSY, 14'h0);
        tick(); checkStep("not_t4", E_T4_UN, 14'h1000);
        tick(); checkStep("not_t5", E_T5, 14'h0);
        tick(); checkStep("not_next_t0", E_T0, SEL_INC);
        run   = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;

        tbl_op[0] = 5'b00101; tbl_sel[0] = 14'h0040; tbl_un[0] = 1'b0;
        tbl_op[1] = 5'b01000; tbl_sel[1] = 14'h0200; tbl_un[1] = 1'b0;
        tbl_op[2] = 5'b01011; tbl_sel[2] = 14'h0020; tbl_un[2] = 1'b0;
        tbl_op[3] = 5'b10001; tbl_sel[3] = 14'h0800; tbl_un[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("tbl%0d", i), tbl_op[i], 1'b0);
            tick(); checkStep($sformatf("tbl%0d_t3", i), tbl_un[i] ? B_BUSY : E_T3_TWO, 14'h0);
            tick(); checkStep($sformatf("tbl%0d_t4", i), tbl_un[i] ? E_T4_UN : E_T4_TWO, tbl_sel[i]);
            tick(); checkStep($sformatf("tbl%0d_t5", i), E_T5, 14'h0);
            tick(); checkStep($sformatf("tbl%0d_idle", i), 20'h0, 14'h0);
        end

        applyStimulus("mul", 5'b01111, 1'b0);
`ifdef ALU_SEQ_MULDIV_EN
        tick(); checkStep("mul_t3", B_GRA | B_R_OUT | B_Y_IN | B_BUSY, 14'h0);
        tick(); checkStep("mul_t4", E_T4_UN, 14'h0004);
        tick(); checkStep("mul_t5", B_ZLO | B_LO_IN | B_BUSY, 14'h0);
        tick(); checkStep("mul_t6", B_ZHI | B_HI_IN | B_BUSY, 14'h0);
        tick(); checkStep("mul_idle", 20'h0, 14'h0);
`else
        tick(); checkStep("mul_illegal", B_ILL, 14'h0);
`endif
        clear = 1'b1;
        tick();
        clear = 1'b0;

        applyStimulus("ill", 5'b11111, 1'b1);
        tick(); checkStep("ill_idle", B_ILL, 14'h0);
        ir = {5'b00011, 27'h0};
        tick(); checkStep("ill_restart_t0", E_T0 | B_ILL, SEL_INC);
        run = 1'b0;
        tick(); checkStep("ill_t1", E_T1 | B_ILL, 14'h0);
        tick(); checkStep("ill_t2", E_T2 | B_ILL, 14'h0);
        tick(); checkStep("ill_t3", E_T3_TWO | B_ILL, 14'h0);
        tick(); checkStep("ill_t4", E_T4_TWO | B_ILL, 14'h0001);
        tick(); checkStep("ill_t5", E_T5 | B_ILL, 14'h0);
        tick(); checkStep("ill_sticky", B_ILL, 14'h0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick(); checkStep("ill_cleared", 20'h0, 14'h0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
